// File: rtl/branch_predictor_pkg.sv
// Shared CPU types: branch operation codes, 2-bit predictor counter states and
// the datapath width used across fetch/execute.
package cpu_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      NONE,
      BEQ,
      BNE,
      BLT,
      BGE,
      BLTU,
      BGEU
   } branch_op_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_state_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and execute update/resolution signals of the branch predictor.
interface branch_predictor_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] PCF;
   logic                  PredTakenF;
   logic [DATA_WIDTH-1:0] PredTargetF;
   logic                  UpdateE;
   logic [DATA_WIDTH-1:0] PCE;
   logic                  TakenE;
   logic [DATA_WIDTH-1:0] TargetE;
   logic                  PredTakenE;
   logic [DATA_WIDTH-1:0] PredTargetE;
   logic                  MispredictE;
   logic [31:0]           BranchCount;
   logic [31:0]           MispredictCount;

   modport master (
      output PCF, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
      input  PredTakenF, PredTargetF, MispredictE, BranchCount, MispredictCount
   );

   modport slave (
      input  PCF, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
      output PredTakenF, PredTargetF, MispredictE, BranchCount, MispredictCount
   );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Per-entry 2-bit saturating direction counter; alloc forces weakly-taken
// when the BTB entry is (re)allocated on a taken miss.
module sat_counter2
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       taken,
   input  logic       alloc,
   output ctr_state_t state
);

   ctr_state_t state_reg, state_next;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= WNT;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (alloc) begin
         state_next = WT;
      end else if (step) begin
         case (state_reg)
            SNT:     state_next = taken ? WNT : SNT;
            WNT:     state_next = taken ? WT  : SNT;
            WT:      state_next = taken ? ST  : WNT;
            ST:      state_next = taken ? ST  : WT;
            default: state_next = WNT;
         endcase
      end
   end

   assign state = state_reg;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: 2-bit counters plus tagged BTB,
// combinational fetch lookup, execute-stage update and accuracy counters.
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_BITS   = 8
) (
   input logic               clk,
   input logic               rst,
   branch_predictor_if.slave bp
);
   import cpu_pkg::*;

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_LO  = INDEX_BITS + 2;
   localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

   logic                  valid_reg  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_reg    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_reg [ENTRIES];
   ctr_state_t            ctr_state  [ENTRIES];

   logic [INDEX_BITS-1:0] idx_f, idx_e;
   logic [TAG_BITS-1:0]   tag_f, tag_e;
   logic                  hit_f, hit_e;
   logic                  mispredict;
   logic [31:0]           bc_reg, mc_reg;

   assign idx_f = bp.PCF[INDEX_BITS+1:2];
   assign tag_f = bp.PCF[TAG_HI:TAG_LO];
   assign idx_e = bp.PCE[INDEX_BITS+1:2];
   assign tag_e = bp.PCE[TAG_HI:TAG_LO];

   // Byte offset and high PC bits take no part in indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.PCF[1:0], bp.PCF[DATA_WIDTH-1:TAG_HI+1],
                             bp.PCE[1:0], bp.PCE[DATA_WIDTH-1:TAG_HI+1]};

   // Lookup reads registered state only, so a same-cycle update is not bypassed.
   assign hit_f = valid_reg[idx_f] && (tag_reg[idx_f] == tag_f);
   assign hit_e = valid_reg[idx_e] && (tag_reg[idx_e] == tag_e);

   assign bp.PredTakenF  = hit_f && ctr_state[idx_f][1];
   assign bp.PredTargetF = hit_f ? target_reg[idx_f] : '0;

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic sel;
         assign sel = bp.UpdateE && (idx_e == INDEX_BITS'(gi));
         sat_counter2 u_ctr (
            .clk   (clk),
            .rst   (rst),
            .step  (sel && hit_e),
            .taken (bp.TakenE),
            .alloc (sel && !hit_e && bp.TakenE),
            .state (ctr_state[gi])
         );
      end
   endgenerate

   // A taken outcome always refreshes the target; a miss also claims the entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_reg[i]  <= 1'b0;
            tag_reg[i]    <= '0;
            target_reg[i] <= '0;
         end
      end else if (bp.UpdateE && bp.TakenE) begin
         if (!hit_e) begin
            valid_reg[idx_e] <= 1'b1;
            tag_reg[idx_e]   <= tag_e;
         end
         target_reg[idx_e] <= bp.TargetE;
      end
   end

   assign mispredict = bp.UpdateE &&
                       ((bp.PredTakenE != bp.TakenE) ||
                        (bp.TakenE && bp.PredTakenE && (bp.PredTargetE != bp.TargetE)));
   assign bp.MispredictE = mispredict;

   always_ff @(posedge clk) begin
      if (rst) begin
         bc_reg <= '0;
         mc_reg <= '0;
      end else begin
         if (bp.UpdateE && (bc_reg != 32'hFFFF_FFFF)) bc_reg <= bc_reg + 32'd1;
         if (mispredict && (mc_reg != 32'hFFFF_FFFF)) mc_reg <= mc_reg + 32'd1;
      end
   end

   assign bp.BranchCount     = bc_reg;
   assign bp.MispredictCount = mc_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: one vector per clock, outputs
// compared against hand-computed values just after the driving negedge.
module tb_branch_predictor;

   logic clk;
   logic rst;

   branch_predictor_if #(.DATA_WIDTH(32)) bp ();

   branch_predictor #(
      .INDEX_BITS (6),
      .DATA_WIDTH (32),
      .TAG_BITS   (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [31:0] pcf;
      logic        upd;
      logic [31:0] pce;
      logic        tk;
      logic [31:0] tgt;
      logic        pte;
      logic [31:0] ptg;
      logic        ept;
      logic [31:0] etg;
      logic        emis;
      logic [31:0] ebc;
      logic [31:0] emc;
   } vec_t;

   vec_t vq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input logic r, input logic [31:0] pcf, input logic upd,
                      input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                      input logic pte, input logic [31:0] ptg, input logic ept,
                      input logic [31:0] etg, input logic emis,
                      input logic [31:0] ebc, input logic [31:0] emc);
      vec_t v;
      v.r = r; v.pcf = pcf; v.upd = upd; v.pce = pce; v.tk = tk; v.tgt = tgt;
      v.pte = pte; v.ptg = ptg; v.ept = ept; v.etg = etg; v.emis = emis;
      v.ebc = ebc; v.emc = emc;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] pcf, input logic upd,
                        input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                        input logic pte, input logic [31:0] ptg);
      rst            = r;
      bp.PCF         = pcf;
      bp.UpdateE     = upd;
      bp.PCE         = pce;
      bp.TakenE      = tk;
      bp.TargetE     = tgt;
      bp.PredTakenE  = pte;
      bp.PredTargetE = ptg;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // rst pcf upd pce tk tgt pte ptg | pt tg mis bc mc (pre-edge)
      add(0, 32'h100, 0, 32'h000, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0,  0, 0);
      add(0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h00,  0, 32'h00,  1,  0, 0);
      add(0, 32'h100, 0, 32'h000, 0, 32'h00,  0, 32'h00,  1, 32'h80,  0,  1, 1);
      add(0, 32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0,  1, 1);
      add(0, 32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0,  2, 1);
      add(0, 32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0,  3, 1);
      add(0, 32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0,  4, 1);
      add(0, 32'h100, 1, 32'h100, 0, 32'h00,  1, 32'h80,  1, 32'h80,  1,  5, 1);
      add(0, 32'h100, 0, 32'h000, 0, 32'h00,  0, 32'h00,  1, 32'h80,  0,  6, 2);
      add(0, 32'h100, 1, 32'h100, 0, 32'h00,  1, 32'h80,  1, 32'h80,  1,  6, 2);
      add(0, 32'h100, 0, 32'h000, 0, 32'h00,  0, 32'h00,  0, 32'h80,  0,  7, 3);
      // alias: same index, tag 2
      add(0, 32'h200, 0, 32'h000, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0,  7, 3);
      add(0, 32'h200, 1, 32'h200, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0,  7, 3);
      add(0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h00,  0, 32'h80,  1,  8, 3);
      add(0, 32'h100, 1, 32'h200, 0, 32'h00,  0, 32'h00,  1, 32'h80,  0,  9, 4);
      add(0, 32'h100, 0, 32'h000, 0, 32'h00,  0, 32'h00,  1, 32'h80,  0, 10, 4);
      add(0, 32'h200, 0, 32'h000, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0, 10, 4);
      // target mismatch
      add(0, 32'h100, 1, 32'h100, 1, 32'h90,  1, 32'h80,  1, 32'h80,  1, 10, 4);
      add(0, 32'h100, 0, 32'h000, 0, 32'h00,  0, 32'h00,  1, 32'h90,  0, 11, 5);
      add(0, 32'h103, 1, 32'h100, 1, 32'h90,  1, 32'h90,  1, 32'h90,  0, 11, 5);
      add(0, 32'h104, 0, 32'h000, 0, 32'h00,  1, 32'h00,  0, 32'h00,  0, 12, 5);
      // collision on index 5
      add(0, 32'h014, 1, 32'h014, 1, 32'h400, 0, 32'h00,  0, 32'h00,  1, 12, 5);
      add(0, 32'h014, 1, 32'h014, 0, 32'h00,  1, 32'h400, 1, 32'h400, 1, 13, 6);
      add(0, 32'h014, 0, 32'h000, 0, 32'h00,  0, 32'h00,  0, 32'h400, 0, 14, 7);
      // reset wins over a simultaneous update
      add(1, 32'h014, 1, 32'h014, 1, 32'h500, 0, 32'h00,  0, 32'h400, 1, 14, 7);
      add(0, 32'h014, 0, 32'h000, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0,  0, 0);
      add(0, 32'h100, 0, 32'h000, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0,  0, 0);

      drive(1, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      repeat (2) @(negedge clk);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].r, vq[i].pcf, vq[i].upd, vq[i].pce, vq[i].tk, vq[i].tgt,
               vq[i].pte, vq[i].ptg);
         #1;
         check("PredTakenF",      i, {31'b0, bp.PredTakenF},  {31'b0, vq[i].ept});
         check("PredTargetF",     i, bp.PredTargetF,          vq[i].etg);
         check("MispredictE",     i, {31'b0, bp.MispredictE}, {31'b0, vq[i].emis});
         check("BranchCount",     i, bp.BranchCount,          vq[i].ebc);
         check("MispredictCount", i, bp.MispredictCount,      vq[i].emc);
         $display("[TB] vec %0d rst=%0b pcf=%h upd=%0b pce=%h tk=%0b -> pt=%0b tg=%h mis=%0b bc=%0d mc=%0d",
                  i, vq[i].r, vq[i].pcf, vq[i].upd, vq[i].pce, vq[i].tk,
                  bp.PredTakenF, bp.PredTargetF, bp.MispredictE,
                  bp.BranchCount, bp.MispredictCount);
      end

      // Allocate eight consecutive entries (indices 8..15, tag 3), then read back.
      for (int k = 0; k < 8; k++) begin
         logic [31:0] pc;
         pc = 32'h300 | ((32'(k) + 32'd8) << 2);
         @(negedge clk);
         drive(0, pc, 1, pc, 1, 32'h1000 + 32'(k) * 32'd16, 0, 32'h0);
         #1;
         check("fill_mis", 100 + k, {31'b0, bp.MispredictE}, 32'd1);
         check("fill_pt",  100 + k, {31'b0, bp.PredTakenF},  32'd0);
         $display("[TB] fill %0d pc=%h tgt=%h mis=%0b", k, pc, bp.TargetE, bp.MispredictE);
      end
      for (int k = 0; k < 8; k++) begin
         logic [31:0] pc;
         pc = 32'h300 | ((32'(k) + 32'd8) << 2);
         @(negedge clk);
         drive(0, pc, 0, 32'h0, 0, 32'h0, 0, 32'h0);
         #1;
         check("read_pt", 200 + k, {31'b0, bp.PredTakenF}, 32'd1);
         check("read_tg", 200 + k, bp.PredTargetF, 32'h1000 + 32'(k) * 32'd16);
         $display("[TB] read %0d pc=%h pt=%0b tg=%h", k, pc, bp.PredTakenF, bp.PredTargetF);
      end
      @(negedge clk);
      drive(0, 32'h220, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      #1;
      check("alias_pt", 300, {31'b0, bp.PredTakenF}, 32'd0);
      check("alias_tg", 300, bp.PredTargetF, 32'd0);
      check("fill_bc",  300, bp.BranchCount, 32'd8);
      check("fill_mc",  300, bp.MispredictCount, 32'd8);
      $display("[TB] alias pc=%h pt=%0b bc=%0d mc=%0d", bp.PCF, bp.PredTakenF,
               bp.BranchCount, bp.MispredictCount);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
